// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Package     : keypad_pkg
// Description : Shared types, matrix dimensions and bit helpers for the
//               4x4 keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } kp_scan_t;

  // Number of asserted bits in a column vector (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Index of the lowest asserted bit; only meaningful when exactly one is set.
  function automatic logic [1:0] first_set4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Interface   : keypad_scanner_if
// Description : Keypad pins plus the decoded key stream. The scanner is the
//               master (drives rows and key outputs); the consumer is slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;

  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );

endinterface
`default_nettype wire

// File: rtl/keypad_scanner_row_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_row_scan
// Description : Holds each row low for SCAN_DIV clocks, then rotates to the
//               next row. Flags the last dwell cycle as the column sample.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_row_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  output logic       sample,
  output logic [1:0] row_idx
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] dwell;

  assign sample = (dwell == CW'(SCAN_DIV - 1));

  // Dwell counter and row rotation; row_n is registered so the pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      row_idx <= 2'd0;
      row_n   <= 4'b1110;
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
      row_n   <= {row_n[2:0], row_n[3]};
    end else begin
      dwell   <= dwell + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad matrix scanner with whole-scan debouncing and
//               ghost-key rejection. Emits key_code with a one-clock
//               key_valid pulse per accepted press.
//               Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 10,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam logic [7:0] DEB_TARGET = 8'(DEBOUNCE_SCANS);

  logic [3:0] row_n;
  logic       sample;
  logic [1:0] row_idx;

  keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_row_scan (
    .clk     (clk),
    .rst     (rst),
    .row_n   (row_n),
    .sample  (sample),
    .row_idx (row_idx)
  );

  // Two-flop synchronizer for the asynchronous column pins (idle = pulled up).
  logic [3:0] col_meta, col_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= kp.col_n;
      col_sync <= col_meta;
    end
  end

  // Per-row contribution folded into the running scan totals.
  logic [1:0] acc_hits;   // saturates at 2: anything beyond one hit is MULTI
  logic [3:0] acc_key;
  logic [2:0] row_hits;
  logic [1:0] row_col;
  logic [2:0] tot_hits;
  logic [3:0] scan_key;
  logic       scan_end;
  kp_scan_t   scan_res;

  assign row_hits = popcount4(~col_sync);
  assign row_col  = first_set4(~col_sync);
  assign tot_hits = {1'b0, acc_hits} + row_hits;
  assign scan_key = (acc_hits == 2'd1) ? acc_key : {row_idx, row_col};
  assign scan_end = sample && (row_idx == 2'(KP_ROWS - 1));

  // Classify the scan including the row being sampled right now.
  always_comb begin
    scan_res = SCAN_NONE;
    if (tot_hits == 3'd1)      scan_res = SCAN_SINGLE;
    else if (tot_hits >= 3'd2) scan_res = SCAN_MULTI;
  end

  // Scan accumulator: collect hits row by row, clear at scan end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hits <= 2'd0;
      acc_key  <= 4'd0;
    end else if (sample) begin
      if (scan_end) begin
        acc_hits <= 2'd0;
        acc_key  <= 4'd0;
      end else begin
        acc_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
        acc_key  <= scan_key;
      end
    end
  end

  kp_state_t  state;
  logic [3:0] cand;
  logic [7:0] cnt;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       single;
  logic       match;
  logic [7:0] cnt_inc;

  assign single  = (scan_res == SCAN_SINGLE);
  assign match   = single && (scan_key == cand);
  assign cnt_inc = cnt + 8'd1;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [15:0] RPT_FIRST = 16'(REPEAT_DELAY);
  localparam logic [15:0] RPT_WRAP  = 16'(REPEAT_DELAY + REPEAT_RATE);
  logic [15:0] rpt;
`else
  if (REPEAT_DELAY < 0 && REPEAT_RATE < 0) begin : g_rpt_params_unused
  end
`endif

  // Debounce FSM, stepped once per completed scan; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= 8'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt       <= 16'd0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        case (state)
          IDLE: begin
            if (single) begin
              cand <= scan_key;
              if (DEBOUNCE_SCANS == 1) begin
                key_code  <= scan_key;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= 8'd0;
                state     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt       <= 16'd0;
`endif
              end else begin
                cnt   <= 8'd1;
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (match) begin
              if (cnt_inc == DEB_TARGET) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= 8'd0;
                state     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt       <= 16'd0;
`endif
              end else begin
                cnt <= cnt_inc;
              end
            end else if (single) begin
              cand <= scan_key;
              cnt  <= 8'd1;
            end else begin
              cnt   <= 8'd0;
              state <= IDLE;
            end
          end
          HELD: begin
            if (match) begin
              cnt <= 8'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
              // After the first repeat, fold back to the delay point so the
              // following repeats come every REPEAT_RATE scans.
              if (rpt + 16'd1 == RPT_WRAP) begin
                rpt       <= RPT_FIRST;
                key_valid <= 1'b1;
              end else begin
                rpt <= rpt + 16'd1;
                if (rpt + 16'd1 == RPT_FIRST) key_valid <= 1'b1;
              end
`endif
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt <= 16'd0;
`endif
              if (cnt_inc == DEB_TARGET) begin
                cnt      <= 8'd0;
                key_down <= 1'b0;
                state    <= IDLE;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          default: begin
            cnt   <= 8'd0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign kp.row_n     = row_n;
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_down  = key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A virtual keypad
//               answers the row strobes; a scan-level model predicts pulses.
//               Honours KEYPAD_AUTOREPEAT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int RDLY     = 4;
  localparam int RRATE    = 2;
  localparam int SCAN_CLK = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scanner_if kp_bus ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_bus)
  );

  // Virtual matrix: a pressed key pulls its column low while its row is driven.
  function automatic logic [3:0] col_drive(input logic [3:0] rn, input logic [15:0] p);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++)
      if (rn[r] == 1'b0)
        for (int k = 0; k < 4; k++)
          if (p[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  assign kp_bus.col_n = col_drive(kp_bus.row_n, pressed);

  // Reference model in terms of scan history.
  bit m_held;
  int m_code, m_down, run_len, run_key, miss_len, rpt;

  task automatic model_reset();
    m_held = 0; m_code = 0; m_down = 0;
    run_len = 0; run_key = 0; miss_len = 0; rpt = 0;
  endtask

  task automatic model_scan(input logic [15:0] p, output bit pulse);
    int n, k;
    n = $countones(p);
    k = 0;
    for (int i = 0; i < 16; i++) if (p[i]) k = i;
    pulse = 0;
    if (!m_held) begin
      if (n == 1) begin
        if (run_len > 0 && run_key == k) run_len++;
        else begin run_len = 1; run_key = k; end
      end else begin
        run_len = 0;
      end
      if (run_len == DEB) begin
        m_held = 1; m_code = k; m_down = 1; pulse = 1; miss_len = 0; rpt = 0;
      end
    end else begin
      if (n == 1 && k == m_code) begin
        miss_len = 0;
        rpt++;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rpt >= RDLY && ((rpt - RDLY) % RRATE) == 0) pulse = 1;
`endif
      end else begin
        miss_len++;
        rpt = 0;
        if (miss_len == DEB) begin
          m_held = 0; m_down = 0; run_len = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full scan with a fixed set of pressed keys, checked every clock.
  task automatic do_scan(input logic [15:0] p, input string tag);
    bit pulse;
    logic [3:0] exp_row;
    pressed = p;
    model_scan(p, pulse);
    for (int k = 1; k <= SCAN_CLK; k++) begin
      @(posedge clk); #1;
      exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check({tag, ".row_n"}, 32'(kp_bus.row_n), 32'(exp_row));
      check({tag, ".key_valid"}, 32'(kp_bus.key_valid), (k == SCAN_CLK) ? 32'(pulse) : 32'd0);
    end
    check({tag, ".key_down"}, 32'(kp_bus.key_down), 32'(m_down));
    check({tag, ".key_code"}, 32'(kp_bus.key_code), 32'(m_code));
  endtask

  task automatic scans(input logic [15:0] p, input int n, input string tag);
    for (int i = 0; i < n; i++) do_scan(p, tag);
  endtask

  initial begin
    logic [15:0] prev_p;
    logic [15:0] rp;
    int sel;

    rst     = 1'b1;
    pressed = 16'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.row_n", 32'(kp_bus.row_n), 32'h0000_000E);
    check("reset.key_valid", 32'(kp_bus.key_valid), 32'd0);
    check("reset.key_down", 32'(kp_bus.key_down), 32'd0);
    check("reset.key_code", 32'(kp_bus.key_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: idle rotation, no pulses
    scans(16'h0, 2, "idle");

    // 2: key 9 (row 2, col 1) held 4 scans then released 3 scans
    scans(16'h0001 << 9, 4, "hold9");
    scans(16'h0, 3, "rel9");

    // 3: interrupted press, then a clean 3-scan press
    scans(16'h0001 << 9, 2, "short9");
    scans(16'h0, 1, "gap9");
    scans(16'h0001 << 9, 3, "repress9");
    scans(16'h0, 3, "rel9b");

    // 4: ghost keys 0 and 5 together, then 0 alone
    scans((16'h0001 << 0) | (16'h0001 << 5), 6, "multi05");
    scans(16'h0001, 3, "only0");
    scans(16'h0, 3, "rel0");

    // 5: reset in the middle of debouncing (cnt = 2)
    scans(16'h0001 << 9, 2, "pre_rst");
    pressed = 16'h0001 << 9;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.row_n", 32'(kp_bus.row_n), 32'h0000_000E);
    check("midrst.key_valid", 32'(kp_bus.key_valid), 32'd0);
    check("midrst.key_down", 32'(kp_bus.key_down), 32'd0);
    check("midrst.key_code", 32'(kp_bus.key_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    scans(16'h0001 << 9, 3, "post_rst9");
    scans(16'h0, 3, "rel9c");

    // 6: key 15 held 12 scans (auto-repeat when enabled)
    scans(16'h0001 << 15, 12, "hold15");
    scans(16'h0, 3, "rel15");

    // Randomized key activity, biased toward holding the previous pattern
    prev_p = 16'h0;
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 1)      rp = 16'h0;
      else if (sel <= 3) rp = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 4) rp = (16'h0001 << $urandom_range(0, 7)) | (16'h0100 << $urandom_range(0, 7));
      else               rp = prev_p;
      do_scan(rp, "rand");
      prev_p = rp;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
